seq_restoring_divider: RTL

//  Sequential unsigned restoring divider; inverse operation of the 4x4 array multiplier.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_step.sv | 49 ++++
 rtl/seq_restoring_divider.sv | 123 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: default widths
// and the IDLE/RUN/DONE state encoding.
package div_pkg;

    localparam int DVD_W_DEF = 8;
    localparam int DSR_W_DEF = 4;
    localparam int CNT_W_DEF = $clog2(DVD_W_DEF);

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder and subtract the divisor through a ripple chain of full adders.
module fadder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module div_step #(
    parameter int DSR_W = 4
) (
    input  logic [DSR_W-1:0] p_i,
    input  logic             dvd_bit_i,
    input  logic [DSR_W-1:0] divisor_i,
    output logic [DSR_W-1:0] p_o,
    output logic             q_o
);
    logic [DSR_W:0]   shifted;
    logic [DSR_W:0]   dsr_inv;
    logic [DSR_W:0]   diff;
    logic [DSR_W+1:0] carry;
    logic             unused_diff_msb;

    assign shifted  = {p_i, dvd_bit_i};
    assign dsr_inv  = ~{1'b0, divisor_i};
    assign carry[0] = 1'b1;

    // a + ~b + 1: the final carry-out is set exactly when the trial is non-negative
    for (genvar i = 0; i <= DSR_W; i++) begin : g_chain
        fadder u_fa (
            .a_i (shifted[i]),
            .b_i (dsr_inv[i]),
            .c_i (carry[i]),
            .s_o (diff[i]),
            .c_o (carry[i+1])
        );
    end

    // The partial remainder stays below the divisor, so its top bit is always zero
    assign unused_diff_msb = diff[DSR_W];
    assign q_o = carry[DSR_W+1];
    assign p_o = q_o ? diff[DSR_W-1:0] : shifted[DSR_W-1:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider producing one quotient bit per clock,
// most significant bit first, with a divide-by-zero shortcut.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int DVD_W = DVD_W_DEF,
    parameter int DSR_W = DSR_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DSR_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DSR_W-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(DVD_W);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DVD_W-1:0]   dvd_q, dvd_d;
    logic [DSR_W-1:0]   dsr_q, dsr_d;
    logic [DSR_W-1:0]   p_q, p_d;
    logic [DVD_W-1:0]   qacc_q, qacc_d;
    logic [DVD_W-1:0]   quot_q, quot_d;
    logic [DSR_W-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;

    logic [DSR_W-1:0]   step_p;
    logic               step_q;
    logic [DVD_W-1:0]   qacc_next;

    div_step #(.DSR_W(DSR_W)) u_step (
        .p_i       (p_q),
        .dvd_bit_i (dvd_q[cnt_q]),
        .divisor_i (dsr_q),
        .p_o       (step_p),
        .q_o       (step_q)
    );

    assign qacc_next = {qacc_q[DVD_W-2:0], step_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        p_d     = p_q;
        qacc_d  = qacc_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d  = dividend;
                    dsr_d  = divisor;
                    p_d    = '0;
                    qacc_d = '0;
                    cnt_d  = CNT_W'(DVD_W - 1);
                    quot_d = '0;
                    rem_d  = '0;
                    dbz_d  = 1'b0;
                    // A zero divisor skips the iterations and reports saturated results
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                p_d    = step_p;
                qacc_d = qacc_next;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quot_d  = qacc_next;
                    rem_d   = step_p;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            p_q     <= '0;
            qacc_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            p_q     <= p_d;
            qacc_q  <= qacc_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
